// File: rtl/fabric_load_arbiter.sv
// Round-robin arbiter sharing one memory load port among NUM_REQ PEs, with an
// in-order ID FIFO steering responses back. Optional counters: FABRIC_LOAD_ARB_PERF_EN.
module fabric_load_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  output logic                              mem_addr_valid,
  input  logic                              mem_addr_ready,
  output logic [ADDR_WIDTH-1:0]             mem_addr_data,
  input  logic                              mem_data_valid,
  output logic                              mem_data_ready,
  input  logic [DATA_WIDTH-1:0]             mem_data_data,
  output logic [NUM_REQ-1:0]                resp_valid,
  input  logic [NUM_REQ-1:0]                resp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0]     resp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
`ifdef FABRIC_LOAD_ARB_PERF_EN
  output logic [NUM_REQ*16-1:0]             perf_grants,
  output logic [15:0]                       perf_full_cycles,
`endif
  output logic                              err_unexpected
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [ID_W-1:0]  fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic             full, empty, arb_found, addr_valid, issue, pop;
  logic [ID_W-1:0]  arb_idx, grant, head;
  int unsigned      scan;

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = (32'(ptr_q) + 32'(i)) % NUM_REQ;
      if (!arb_found && req_valid[scan]) begin
        arb_found = 1'b1;
        arb_idx   = ID_W'(scan);
      end
    end
  end

  // A locked grant is held regardless of FIFO state; it was taken with space available.
  always_comb begin
    full       = (count_q == CNT_W'(MAX_OUTSTANDING));
    empty      = (count_q == '0);
    grant      = lock_q ? grant_q : arb_idx;
    addr_valid = lock_q || (!full && arb_found);
    issue      = addr_valid && mem_addr_ready;
    head       = fifo_q[rd_ptr_q];
    pop        = mem_data_valid && !empty && resp_ready[head];
  end

  always_comb begin
    ptr_d    = ptr_q;
    lock_d   = lock_q;
    grant_d  = grant;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q || (mem_data_valid && empty);
    if (issue) begin
      ptr_d            = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
      lock_d           = 1'b0;
      fifo_d[wr_ptr_q] = grant;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end else if (addr_valid) begin
      lock_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({issue, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      lock_q   <= 1'b0;
      grant_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      lock_q   <= lock_d;
      grant_q  <= grant_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  assign mem_addr_valid = addr_valid;
  assign mem_addr_data  = req_addr[32'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign req_ready      = issue ? (NUM_REQ'(1) << grant) : '0;
  assign resp_valid     = (mem_data_valid && !empty) ? (NUM_REQ'(1) << head) : '0;
  assign mem_data_ready = !empty && resp_ready[head];
  assign resp_data      = {NUM_REQ{mem_data_data}};
  assign outstanding    = count_q;
  assign err_unexpected = err_q;

`ifdef FABRIC_LOAD_ARB_PERF_EN
  logic [15:0] perf_grants_q [NUM_REQ];
  logic [15:0] perf_grants_d [NUM_REQ];
  logic [15:0] perf_full_q, perf_full_d;

  // Saturating event counters.
  always_comb begin
    perf_grants_d = perf_grants_q;
    perf_full_d   = perf_full_q;
    if (issue && perf_grants_q[grant] != 16'hFFFF) begin
      perf_grants_d[grant] = perf_grants_q[grant] + 16'd1;
    end
    if (full && |req_valid && perf_full_q != 16'hFFFF) begin
      perf_full_d = perf_full_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_full_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) perf_grants_q[i] <= '0;
    end else begin
      perf_full_q <= perf_full_d;
      for (int i = 0; i < NUM_REQ; i++) perf_grants_q[i] <= perf_grants_d[i];
    end
  end

  always_comb begin
    perf_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) perf_grants[i*16 +: 16] = perf_grants_q[i];
  end
  assign perf_full_cycles = perf_full_q;
`endif

endmodule

// File: tb/tb_fabric_load_arbiter.sv
// Directed bench for fabric_load_arbiter: queue-based reference model checked every
// cycle, plus literal expectations for grant order, hold, routing, full and reset.
module tb_fabric_load_arbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic            mem_addr_valid;
  logic            mem_addr_ready = 1'b0;
  logic [AW-1:0]   mem_addr_data;
  logic            mem_data_valid = 1'b0;
  logic            mem_data_ready;
  logic [DW-1:0]   mem_data_data = '0;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready = '0;
  logic [N*DW-1:0] resp_data;
  logic [3:0]      outstanding;
  logic            err_unexpected;

  fabric_load_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready),
    .mem_addr_data(mem_addr_data),
    .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready),
    .mem_data_data(mem_data_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit run    = 1'b0;

  // Reference model: rotating pointer, pending (held) grant, queue of outstanding IDs.
  int m_ptr = 0;
  bit m_held = 1'b0;
  int m_held_id = 0;
  int m_q[$];
  bit m_err = 1'b0;
  int issued[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_cycle();
    int g, c, head;
    bit av, full, iss, pop;
    logic [N-1:0] ex_rv;
    bit ex_mdr;
    if (!rst_n) begin
      m_ptr = 0; m_held = 1'b0; m_q.delete(); m_err = 1'b0;
      chk("rst_mem_addr_valid", 64'(mem_addr_valid), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("rst_mem_data_ready", 64'(mem_data_ready), 64'(0));
      chk("rst_outstanding", 64'(outstanding), 64'(0));
      chk("rst_err", 64'(err_unexpected), 64'(0));
      return;
    end
    full = (m_q.size() == MAXO);
    g = 0; av = 1'b0;
    if (m_held) begin
      g = m_held_id; av = 1'b1;
    end else if (!full) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!av && req_valid[c]) begin g = c; av = 1'b1; end
      end
    end
    iss    = av && mem_addr_ready;
    head   = (m_q.size() > 0) ? m_q[0] : 0;
    ex_rv  = (m_q.size() > 0 && mem_data_valid) ? N'(1 << head) : '0;
    ex_mdr = (m_q.size() > 0) && resp_ready[head];
    pop    = mem_data_valid && ex_mdr;

    chk("mem_addr_valid", 64'(mem_addr_valid), 64'(av));
    if (av) chk("mem_addr_data", 64'(mem_addr_data), 64'(req_addr[g*AW +: AW]));
    chk("req_ready", 64'(req_ready), iss ? 64'(1 << g) : 64'(0));
    chk("resp_valid", 64'(resp_valid), 64'(ex_rv));
    chk("mem_data_ready", 64'(mem_data_ready), 64'(ex_mdr));
    chk("outstanding", 64'(outstanding), 64'(m_q.size()));
    chk("err_unexpected", 64'(err_unexpected), 64'(m_err));
    if (mem_data_valid)
      for (int k = 0; k < N; k++) chk("resp_data", 64'(resp_data[k*DW +: DW]), 64'(mem_data_data));

    if (mem_addr_valid && mem_addr_ready)
      for (int k = 0; k < N; k++) if (req_ready[k]) issued.push_back(k);

    if (mem_data_valid && m_q.size() == 0) m_err = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (iss) begin
      m_q.push_back(g);
      m_ptr  = (g + 1) % N;
      m_held = 1'b0;
    end else if (av) begin
      m_held = 1'b1; m_held_id = g;
    end
  endtask

  always @(negedge clk) if (run) model_cycle();

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_addr(input int lane, input logic [AW-1:0] a);
    req_addr[lane*AW +: AW] = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};
    run = 1'b1;
    step(); step();
    #1;
    chk("reset_outstanding", 64'(outstanding), 64'(0));
    chk("reset_mem_addr_valid", 64'(mem_addr_valid), 64'(0));
    rst_n = 1'b1;
    resp_ready = '1;
    step();

    // Round-robin with every requester asserting.
    for (int i = 0; i < N; i++) set_addr(i, AW'(32'h1000 * (i + 1)));
    req_valid = '1; mem_addr_ready = 1'b1;
    repeat (5) step();
    req_valid = '0;
    #1;
    chk("rr_outstanding", 64'(outstanding), 64'(5));
    chk("rr_model_depth", 64'(m_q.size()), 64'(5));
    chk("rr_count", 64'(issued.size()), 64'(5));
    for (int i = 0; i < 5 && i < issued.size(); i++) chk("rr_order", 64'(issued[i]), 64'(exp_rr[i]));
    mem_data_valid = 1'b1; mem_data_data = 32'h55;
    repeat (5) step();
    mem_data_valid = 1'b0;
    #1 chk("rr_drained", 64'(outstanding), 64'(0));

    // In-order routing: issue 1 then 3, respond AA then BB.
    set_addr(1, 32'h10); set_addr(3, 32'h20);
    req_valid = 4'b1010;
    step();
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    #1 chk("route_outstanding2", 64'(outstanding), 64'(2));
    mem_data_valid = 1'b1; mem_data_data = 32'hAA;
    #1;
    chk("route_resp_valid1", 64'(resp_valid), 64'(4'b0010));
    chk("route_data1", 64'(resp_data[1*DW +: DW]), 64'(32'hAA));
    step();
    mem_data_data = 32'hBB;
    #1;
    chk("route_outstanding1", 64'(outstanding), 64'(1));
    chk("route_resp_valid3", 64'(resp_valid), 64'(4'b1000));
    chk("route_data3", 64'(resp_data[3*DW +: DW]), 64'(32'hBB));
    step();
    mem_data_valid = 1'b0;
    #1 chk("route_outstanding0", 64'(outstanding), 64'(0));

    // Hold: req2 stalled, req0 joins but the locked grant stays on 2.
    issued.delete();
    set_addr(2, 32'h100); set_addr(0, 32'h200);
    req_valid = 4'b0100; mem_addr_ready = 1'b0;
    repeat (3) begin
      #1 chk("hold_addr", 64'(mem_addr_data), 64'(32'h100));
      step();
    end
    req_valid = 4'b0101;
    #1;
    chk("hold_addr_req0", 64'(mem_addr_data), 64'(32'h100));
    chk("hold_valid", 64'(mem_addr_valid), 64'(1));
    step();
    mem_addr_ready = 1'b1;
    #1 chk("hold_accept", 64'(req_ready), 64'(4'b0100));
    step();
    req_valid = 4'b0001;
    #1 chk("hold_next_addr", 64'(mem_addr_data), 64'(32'h200));
    step();
    req_valid = '0;
    #1;
    chk("hold_count", 64'(issued.size()), 64'(2));
    if (issued.size() == 2) begin
      chk("hold_first", 64'(issued[0]), 64'(2));
      chk("hold_second", 64'(issued[1]), 64'(0));
    end
    mem_data_valid = 1'b1;
    repeat (2) step();
    mem_data_valid = 1'b0;

    // Full FIFO blocks new grants until a pop frees a slot.
    req_valid = '1;
    repeat (8) step();
    #1;
    chk("full_outstanding", 64'(outstanding), 64'(8));
    chk("full_no_valid", 64'(mem_addr_valid), 64'(0));
    step();
    mem_data_valid = 1'b1;
    #1 chk("full_pop_ready", 64'(mem_data_ready), 64'(1));
    step();
    mem_data_valid = 1'b0;
    #1;
    chk("full_after_pop", 64'(outstanding), 64'(7));
    chk("full_reissue", 64'(mem_addr_valid), 64'(1));
    step();
    req_valid = '0;
    #1 chk("full_refilled", 64'(outstanding), 64'(8));
    mem_data_valid = 1'b1;
    repeat (8) step();
    mem_data_valid = 1'b0;
    #1 chk("full_drained", 64'(outstanding), 64'(0));

    // Backpressure, then push and pop together at occupancy 1.
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    resp_ready = '0; mem_data_valid = 1'b1;
    #1 chk("bp_no_ready", 64'(mem_data_ready), 64'(0));
    step();
    #1 chk("bp_no_pop", 64'(outstanding), 64'(1));
    resp_ready = '1; req_valid = 4'b0100; set_addr(2, 32'h300);
    step();
    req_valid = '0;
    #1;
    chk("simul_outstanding", 64'(outstanding), 64'(1));
    chk("simul_head", 64'(resp_valid), 64'(4'b0100));
    step();
    mem_data_valid = 1'b0;
    #1 chk("simul_drained", 64'(outstanding), 64'(0));

    // Unexpected response, then reset with requests outstanding.
    mem_data_valid = 1'b1;
    #1 chk("err_stall", 64'(mem_data_ready), 64'(0));
    step();
    mem_data_valid = 1'b0;
    #1 chk("err_set", 64'(err_unexpected), 64'(1));
    step();
    #1 chk("err_sticky", 64'(err_unexpected), 64'(1));
    req_valid = '1;
    repeat (3) step();
    req_valid = '0; mem_addr_ready = 1'b0;
    #1 chk("pre_reset_outstanding", 64'(outstanding), 64'(3));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_outstanding", 64'(outstanding), 64'(0));
    chk("mid_reset_err", 64'(err_unexpected), 64'(0));
    chk("mid_reset_valid", 64'(mem_addr_valid), 64'(0));
    chk("mid_reset_resp_valid", 64'(resp_valid), 64'(0));
    step(); step();
    rst_n = 1'b1;
    issued.delete();
    req_valid = '1; mem_addr_ready = 1'b1;
    step();
    req_valid = '0;
    #1;
    chk("post_reset_count", 64'(issued.size()), 64'(1));
    if (issued.size() == 1) chk("post_reset_ptr0", 64'(issued[0]), 64'(0));
    step();
    run = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
